// File: rtl/nibble_add_sequencer.sv
// ---------------------------------------------------------------------------
// nibble_add_sequencer
//
// Purpose:
//   Adds two W = 4*NIBBLES bit operands with one shared 4-bit ripple-carry
//   slice. It processes one nibble per clock, starting with the LSB nibble.
//   The carry is registered between nibbles. Operands come in and results go
//   out over valid/ready handshakes.
//
// Optional feature (macro SUB_EN):
//   When SUB_EN is defined, in_sub=1 selects A-B. B is inverted and the
//   carry-in is forced to 1.
//   When SUB_EN is undefined, in_sub is ignored and every operation is
//   A+B+in_cin.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept operands (registered)
//   in_a       operand A, W bits
//   in_b       operand B, W bits
//   in_cin     carry-in (add only)
//   in_sub     1 = subtract (only with SUB_EN)
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   out_sum    W-bit result
//   out_cout   carry out of the MSB nibble (no-borrow flag when subtracting)
//   out_ovf    signed overflow
// ---------------------------------------------------------------------------

// 4-bit ripple-carry slice built from full adders.
module ripple_carry_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;

   assign c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fa
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = c[4];
endmodule

module nibble_add_sequencer #(
   parameter int NIBBLES = 4,
   parameter int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         out_ovf
);
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic            carry;
   logic [IW-1:0]   idx;
   logic            a_msb;
   logic            b_msb;

   // Operand B after optional inversion, and the effective carry-in.
   logic [W-1:0]    b_prime;
   logic            cin_eff;

`ifdef SUB_EN
   assign b_prime = in_sub ? ~in_b : in_b;
   assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
   logic unused_sub;
   assign unused_sub = in_sub;
   assign b_prime    = in_b;
   assign cin_eff    = in_cin;
`endif

   logic [3:0] slice_sum;
   logic       slice_cout;

   ripple_carry_adder u_slice (
      .a    (a_sh[3:0]),
      .b    (b_sh[3:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready is low for the first IDLE cycle after reset.
               // It rises one cycle later.
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_sh     <= in_a;
                  b_sh     <= b_prime;
                  carry    <= cin_eff;
                  idx      <= '0;
                  a_msb    <= in_a[W-1];
                  b_msb    <= b_prime[W-1];
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               // Result nibbles enter from the top. After NIBBLES shifts,
               // the first nibble has reached the LSB position.
               out_sum <= {slice_sum, out_sum[W-1:4]};
               carry   <= slice_cout;
               a_sh    <= a_sh >> 4;
               b_sh    <= b_sh >> 4;
               idx     <= idx + 1'b1;
               if (idx == LAST) begin
                  out_cout  <= slice_cout;
                  // slice_sum[3] is the final result MSB.
                  out_ovf   <= (a_msb == b_msb) && (slice_sum[3] != a_msb);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;
   localparam int NIBBLES = 4;
   localparam int W       = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;

   int checks = 0;
   int errors = 0;

   // Results returned by run_op.
   logic [W-1:0]  got_sum;
   logic          got_cout;
   logic          got_ovf;
   int            got_lat;

   nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // Reference model uses plain integer arithmetic.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] sum, output logic cout,
                                 output logic ovf);
      int ua, ub, sa, sb, total, st;
      logic do_sub;
`ifdef SUB_EN
      do_sub = sub;
`else
      do_sub = 1'b0;
`endif
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (do_sub) begin
         total = ua - ub;
         cout  = (ua >= ub);
         st    = sa - sb;
      end else begin
         total = ua + ub + int'(cin);
         cout  = (total >= 65536);
         st    = sa + sb + int'(cin);
      end
      sum = W'(total);
      ovf = (st > 32767) || (st < -32768);
   endfunction

   // Drives one operation and collects the result.
   // got_lat counts cycles from the accept edge to out_valid.
   // It is 99 on a timeout.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
      int n;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      in_valid = 1'b1;
      out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         got_lat = 99; got_sum = 'x; got_cout = 1'bx; got_ovf = 1'bx;
         return;
      end
      @(posedge clk); #1;              // accept edge
      in_valid = 1'b0;
      got_lat = 0;
      while (!out_valid && got_lat < 50) begin
         @(posedge clk); #1; got_lat++;
      end
      if (!out_valid) got_lat = 99;
      got_sum = out_sum; got_cout = out_cout; got_ovf = out_ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 16'h0000 ||
          out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b sum=%h cout=%b ovf=%b required 0 0 0000 0 0",
                  out_valid, in_ready, out_sum, out_cout, out_ovf);
      end else $display("reset_state ok");
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end else $display("reset_release_ready ok");
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [6];
      logic [W-1:0] tb [6];
      logic         tc [6];
      logic         ts [6];
      logic [W-1:0] es [6];
      logic         ec [6];
      logic         eo [6];
      int           n;
      ta[0]=16'h1234; tb[0]=16'h4321; tc[0]=0; ts[0]=0; es[0]=16'h5555; ec[0]=0; eo[0]=0;
      ta[1]=16'hFFFF; tb[1]=16'h0001; tc[1]=0; ts[1]=0; es[1]=16'h0000; ec[1]=1; eo[1]=0;
      ta[2]=16'h0000; tb[2]=16'h0000; tc[2]=1; ts[2]=0; es[2]=16'h0001; ec[2]=0; eo[2]=0;
      ta[3]=16'h7FFF; tb[3]=16'h0001; tc[3]=0; ts[3]=0; es[3]=16'h8000; ec[3]=0; eo[3]=1;
      ta[4]=16'h8000; tb[4]=16'h8000; tc[4]=0; ts[4]=0; es[4]=16'h0000; ec[4]=1; eo[4]=1;
`ifdef SUB_EN
      ta[5]=16'h0005; tb[5]=16'h0007; tc[5]=0; ts[5]=1; es[5]=16'hFFFE; ec[5]=0; eo[5]=0;
      n = 7;
`else
      ta[5]=16'h0005; tb[5]=16'h0007; tc[5]=0; ts[5]=1; es[5]=16'h000C; ec[5]=0; eo[5]=0;
      n = 6;
`endif
      for (int i = 0; i < n; i++) begin
         logic [W-1:0] xa, xb, xs;
         logic xc, xsb, xco, xo;
         if (i < 6) begin
            xa = ta[i]; xb = tb[i]; xc = tc[i]; xsb = ts[i];
            xs = es[i]; xco = ec[i]; xo = eo[i];
         end else begin
            xa = 16'h8000; xb = 16'h0001; xc = 1'b0; xsb = 1'b1;
            xs = 16'h7FFF; xco = 1'b1; xo = 1'b1;
         end
         run_op(xa, xb, xc, xsb);
         checks++;
         if (got_sum !== xs || got_cout !== xco || got_ovf !== xo || got_lat != NIBBLES) begin
            errors++;
            $display("FAIL directed_%0d: %h op %h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d required sum=%h cout=%b ovf=%b lat=%0d",
                     i, xa, xb, xc, xsb, got_sum, got_cout, got_ovf, got_lat, xs, xco, xo, NIBBLES);
         end else
            $display("directed_%0d: %h op %h cin=%b sub=%b -> %h cout=%b ovf=%b lat=%0d",
                     i, xa, xb, xc, xsb, got_sum, got_cout, got_ovf, got_lat);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a, b, es;
         logic c, s, ec, eo;
         a = W'($urandom);
         b = W'($urandom);
         c = 1'($urandom);
         s = 1'($urandom);
         model(a, b, c, s, es, ec, eo);
         run_op(a, b, c, s);
         checks++;
         if (got_sum !== es || got_cout !== ec || got_ovf !== eo || got_lat != NIBBLES) begin
            errors++;
            $display("FAIL random_%0d: %h op %h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d required sum=%h cout=%b ovf=%b lat=%0d",
                     i, a, b, c, s, got_sum, got_cout, got_ovf, got_lat, es, ec, eo, NIBBLES);
         end else
            $display("random_%0d: %h op %h cin=%b sub=%b -> %h cout=%b ovf=%b",
                     i, a, b, c, s, got_sum, got_cout, got_ovf);
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic bad;
      logic [W-1:0] es;
      logic ec, eo;
      in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      // Present new operands while the first operation is still in flight.
      in_a = 16'h0F0F; in_b = 16'h00F1; in_cin = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h3333) bad = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL backpressure_hold: valid=%b ready=%b sum=%h required 1 0 3333 for 5 cycles",
                  out_valid, in_ready, out_sum);
      end else $display("backpressure_hold: sum=3333 held 5 cycles, in_ready=0");
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
      end else $display("backpressure_release: back in IDLE");
      @(posedge clk); #1;              // new operands accepted here
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      model(16'h0F0F, 16'h00F1, 1'b1, 1'b0, es, ec, eo);
      checks++;
      if (out_sum !== es || out_cout !== ec || out_ovf !== eo || n != NIBBLES) begin
         errors++;
         $display("FAIL backpressure_next: sum=%h cout=%b ovf=%b lat=%0d required %h %b %b lat=%0d",
                  out_sum, out_cout, out_ovf, n, es, ec, eo, NIBBLES);
      end else $display("backpressure_next: 0f0f+00f1+1 -> %h", out_sum);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_abort();
      int n;
      logic seen;
      in_a = 16'hABCD; in_b = 16'h1234; in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;              // accept
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end else $display("abort_ready: in_ready=1 after reset release");
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_no_valid: out_valid=1 seen required 0");
      end else $display("abort_no_valid: aborted result never presented");
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
      checks++;
      if (got_sum !== 16'h0003 || got_cout !== 1'b0 || got_ovf !== 1'b0 || got_lat != NIBBLES) begin
         errors++;
         $display("FAIL abort_next: sum=%h cout=%b ovf=%b lat=%0d required 0003 0 0 lat=%0d",
                  got_sum, got_cout, got_ovf, got_lat, NIBBLES);
      end else $display("abort_next: 0001+0002 -> %h lat=%0d", got_sum, got_lat);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle wide-operand adder controller that time-shares a single 4-bit `ripple_carry_adder` slice. It adds operands of width 4×NIBBLES, one nibble per clock, LSB nibble first. The carry is registered between nibbles. Operands are accepted and results returned over valid/ready handshakes. It sits between an operand producer and a result consumer wherever a wide add is needed but only one 4-bit slice is budgeted.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; legal ≥ 2; W = 4×NIBBLES
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous and active-low; one clock domain, no other clock
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operands
- in_a  input  W  operand A (two's complement)
- in_b  input  W  operand B
- in_cin  input  1  carry-in for add
- in_sub  input  1  1 = A−B (honoured only with SUB_EN)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  W  result
- out_cout  output  1  carry out of MSB nibble (no-borrow flag for subtract)
- out_ovf  output  1  signed overflow

## Operation
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid && in_ready: capture A and B′ into shift registers, load carry register, clear nibble index, latch the MSBs of A and B′, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle the slice adds A[3:0] + B′[3:0] + carry. The slice sum nibble is shifted into out_sum from the top (register shifts right by 4). The carry register takes the slice Cout. The A and B′ registers shift right by 4. The index increments. When index = NIBBLES−1, go to DONE.
  - DONE: out_valid=1. out_sum, out_cout and out_ovf are held stable. On out_valid && out_ready, go to IDLE.
- B′ = in_b for add. B′ = ~in_b with carry-in forced to 1 for subtract; in_cin is ignored when subtracting.
- out_cout = final carry register value.
- out_ovf = (A_msb == B′_msb) && (out_sum[W−1] != A_msb).
- All arithmetic is modulo 2^W. No saturation.
- in_valid during RUN or DONE is ignored; the operands are not captured. The producer holds them until in_ready.
- No accept in the same cycle as a result handshake. in_ready rises the cycle after DONE→IDLE.
- Reset mid-operation aborts. The partial result is discarded and out_valid is never raised for the aborted operation.

## Timing
- Reset values while rst_n=0 at a clk edge:
  - state=IDLE; out_valid=0; out_sum=0; out_cout=0; out_ovf=0
  - in_ready=0 while rst_n is low, 1 in the first cycle after release
- Latency: if operands are accepted at edge k, out_valid is 1 from the cycle following edge k+NIBBLES.
- Throughput: at most one result per NIBBLES+2 cycles when out_ready is held high.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from inputs.
- out_* registers change only in RUN and on reset. They are stable for the whole DONE interval, under any backpressure duration.

## Configuration
- SUB_EN defined:
  - in_sub=1 selects subtraction (B inverted, carry-in 1).
  - in_sub is captured with the operands.
- SUB_EN undefined:
  - No inversion logic and no in_sub capture register.
  - in_sub is still a port but is ignored; every operation is A+B+in_cin.

## Test plan
- NIBBLES=4, 0x1234 + 0x4321, cin=0 → out_sum=0x5555, cout=0, ovf=0; out_valid first high exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, cin=0 → out_sum=0x0000, cout=1, ovf=0 (carry crosses all nibble boundaries); 0x0000 + 0x0000, cin=1 → 0x0001.
- 0x7FFF + 0x0001 → out_sum=0x8000, cout=0, ovf=1; 0x8000 + 0x8000 → 0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → out_sum held, in_ready=0, new operands not taken. Raise out_ready → IDLE next cycle, then new operands accepted.
- SUB_EN defined: 0x0005 − 0x0007 → 0xFFFE, cout=0, ovf=0; 0x8000 − 0x0001 → 0x7FFF, cout=1, ovf=1. SUB_EN undefined with in_sub=1: 0x0005, 0x0007 → 0x000C.
- Pull rst_n low for one cycle two cycles into RUN → out_valid stays 0 and in_ready=1 after release. The next accepted 0x0001 + 0x0002 → 0x0003 with normal latency.
